// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, bus widths and writer state encoding.
package fb_pkg;

    localparam int unsigned FB_COLS   = 160;
    localparam int unsigned FB_ROWS   = 120;
    localparam int unsigned FB_WORDS  = FB_COLS * FB_ROWS / 2;
    localparam int unsigned FB_ADDR_W = 14;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_PIX_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FILL   = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_word_packer.sv
// Packs two consecutive 8-bit pixels into one 16-bit framebuffer word.
module fb_word_packer
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [FB_PIX_W-1:0]  pix_data,
    output logic                 word_valid,
    output logic [FB_DATA_W-1:0] word
);

    logic                phase_q;
    logic [FB_PIX_W-1:0] held_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            held_q  <= '0;
        end else if (clear) begin
            phase_q <= 1'b0;
            held_q  <= '0;
        end else if (accept) begin
            if (!phase_q) begin
                held_q <= pix_data;
            end
            phase_q <= ~phase_q;
        end
    end

    // Second pixel of a pair goes in the high byte, straight from the input.
    assign word_valid = accept & phase_q & ~clear;
    assign word       = {pix_data, held_q};

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: streams raster pixels or fills the frame with one colour,
// sharing the memory port with the display reader through mem_grant.
module fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned FB_WORDS = fb_pkg::FB_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_frame,
    input  logic        fill_req,
    input  logic [7:0]  fill_color,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    input  logic        mem_grant,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

    fb_state_t            state_q, state_d;
    logic [FB_ADDR_W-1:0] ptr_q, ptr_d;
    logic                 pending_q, pending_d;
    logic [FB_DATA_W-1:0] din_q, din_d;
    logic                 done_q, done_d;

    logic                 restart;
    logic                 accept;
    logic                 pack_clear;
    logic                 word_valid;
    logic [FB_DATA_W-1:0] word;

    assign restart    = (state_q == STREAM) && start_frame;
    assign pack_clear = ((state_q == IDLE) && (start_frame || fill_req)) || restart;

    // A restart cycle neither writes nor accepts: everything in flight is dropped.
    assign mem_we     = pending_q & mem_grant & ~restart;
    assign pix_ready  = (state_q == STREAM) & ~pending_q & ~start_frame;
    assign accept     = pix_valid & pix_ready;

    assign mem_addr   = ptr_q;
    assign mem_din    = din_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

    fb_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .accept     (accept),
        .pix_data   (pix_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            pending_q <= 1'b0;
            din_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            din_q     <= din_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        din_d     = din_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d   = FILL;
                    ptr_d     = '0;
                    pending_d = 1'b1;
                    din_d     = {fill_color, fill_color};
                end else if (start_frame) begin
                    state_d   = STREAM;
                    ptr_d     = '0;
                    pending_d = 1'b0;
                end
            end
            STREAM: begin
                if (start_frame) begin
                    ptr_d     = '0;
                    pending_d = 1'b0;
                end else if (mem_we) begin
                    pending_d = 1'b0;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else if (word_valid) begin
                    pending_d = 1'b1;
                    din_d     = word;
                end
            end
            FILL: begin
                // Pending stays high so every granted cycle writes the next word.
                if (mem_we) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d   = IDLE;
                        ptr_d     = '0;
                        pending_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                ptr_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter FB_WORDS, default 9600, frame length in 16-bit words (160x120 pixels, 2 pixels/word).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_frame  input  1  single-cycle pulse; begin raster-order pixel stream at word 0.
REQ-005 SHALL have port fill_req  input  1  single-cycle pulse; clear whole frame to fill_color.
REQ-006 SHALL have port fill_color  input  8  fill colour, sampled in the cycle fill_req is accepted.
REQ-007 SHALL have port pix_valid  input  1  stream pixel valid.
REQ-008 SHALL have port pix_data  input  8  stream pixel colour, RRRGGGBB.
REQ-009 SHALL have port pix_ready  output  1  writer accepts pixel this cycle.
REQ-010 SHALL have port mem_grant  input  1  memory port granted to writer this cycle (display reader idle/blanking).
REQ-011 SHALL have port mem_we  output  1  framebuffer write enable.
REQ-012 SHALL have port mem_addr  output  14  framebuffer word address.
REQ-013 SHALL have port mem_din  output  16  framebuffer write data.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after last word written.

Function
REQ-016 SHALL implement states IDLE, STREAM, FILL.
REQ-017 IDLE: fill_req -> FILL; start_frame -> STREAM; both in same cycle -> FILL; word pointer and byte phase cleared on either transition.
REQ-018 Pixel transfer SHALL occur only in a cycle with pix_valid=1 and pix_ready=1.
REQ-019 pix_ready SHALL be 1 only in STREAM with no write pending; 0 in IDLE and FILL.
REQ-020 STREAM phase 0: accepted pixel stored as low byte; phase toggles to 1.
REQ-021 STREAM phase 1: accepted pixel forms word {pix_data, low byte} in mem_din, mem_addr = pointer, pending set, phase returns to 0.
REQ-022 mem_we SHALL equal pending AND mem_grant (combinational); mem_addr/mem_din registered and stable while pending.
REQ-023 A write completes in every cycle mem_we=1; pointer increments by 1 on completion; pending clears unless further words remain (FILL).
REQ-024 Latency: pixel pair completed at cycle N -> mem_we earliest at N+1 (grant high); pix_ready returns 1 the cycle after write completes.
REQ-025 mem_grant low SHALL stall indefinitely without loss or duplication of data.
REQ-026 start_frame during STREAM SHALL restart: pointer 0, phase 0, held byte and pending write discarded, no mem_we that cycle.
REQ-027 FILL: mem_din = {fill_color, fill_color}, pending held high; one word written per granted cycle, addresses 0..FB_WORDS-1 in order.
REQ-028 start_frame and fill_req SHALL be ignored during FILL; fill_req during STREAM ignored.
REQ-029 After write to address FB_WORDS-1 completes (either mode): frame_done=1 next cycle for exactly one cycle, state -> IDLE, pointer 0; pixels offered afterwards not accepted.
REQ-030 Pointer width 14 bits; SHALL never exceed FB_WORDS-1 (no wrap past frame end).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, pointer 0, phase 0, pending 0, held byte 0, mem_we/mem_addr/mem_din/pix_ready/busy/frame_done all 0.
REQ-032 Reset asserted mid-write SHALL drop mem_we in same cycle; no partial frame_done.

Structure
REQ-033 Shared package fb_pkg SHALL hold FB_COLS=160, FB_ROWS=120, FB_WORDS, FB_ADDR_W=14, FB_DATA_W=16, state encoding.
REQ-034 One sub-module fb_word_packer (byte phase, held byte, 16-bit word assembly) SHALL be used; FSM, pointer, grant logic stay in fb_writer.

Verification
REQ-035 Reset, start_frame, pixels 0x11,0x22 with grant=1 -> mem_we one cycle, mem_addr=0, mem_din=0x2211.
REQ-036 Same pair with grant=0 for 5 cycles then 1 -> pix_ready=0 throughout stall, exactly one write 0x2211 at addr 0.
REQ-037 fill_req with fill_color=0xE3, grant=1 -> 9600 writes of 0xE3E3, addr 0..9599 consecutive, busy high, frame_done pulse one cycle after addr 9599.
REQ-038 STREAM after 3 pixels (0xAA,0xBB,0xCC), start_frame, then 0x01,0x02 -> write 0x0201 at addr 0, no write with 0xCC.
REQ-039 Full 19200-pixel stream with random grant -> 9600 writes, each address once, frame_done once, 19201st pixel not accepted.
REQ-040 rst_n low mid-FILL at addr 500 -> mem_we 0 immediately, busy 0, frame_done never pulses.
